pc_fetch_unit: RTL

//  Program-counter register, next-PC selection and instruction-fetch handshake.

---
 rtl/pc_fetch_unit_if.sv | 22 ++
 rtl/pc_fetch_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between the PC/fetch unit and instruction memory.
// The master issues requests; the slave answers with ack and the fetched word.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter, next-PC selection and multi-cycle instruction fetch FSM.
// Supplies instr to decode/ctrl and takes back their jump decisions.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jmp_en,
  input  logic        jmpr_en,
  input  logic        jmpb_en,
  input  logic [31:0] imm,
  input  logic [31:0] data_rs1,
  input  logic        stall,
  pc_fetch_unit_if.master imem,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    EXEC,
    TRAP
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] target;
  logic        misalign;

  assign pc_plus4 = pc + 32'd4;

  // JALR outranks JAL/branch; JAL and branch share the pc-relative adder
  always_comb begin
    target = pc_plus4;
    if (jmpr_en) begin
      target = (data_rs1 + imm) & 32'hFFFF_FFFE;
    end else if (jmp_en || jmpb_en) begin
      target = pc + imm;
    end
  end

  assign misalign = |target[1:0];

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    unique case (state)
      BOOT: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        if (imem.imem_ack) begin
          instr_nxt = imem.imem_rdata;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          if (misalign) begin
            state_nxt = TRAP;
          end else begin
            pc_nxt    = target;
            state_nxt = FETCH;
          end
        end
      end
      TRAP: begin
        state_nxt = TRAP;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
      instr <= NOP;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      instr <= instr_nxt;
    end
  end

  // TRAP is only left through reset, so the error flag is naturally sticky
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == EXEC);
  assign misalign_err   = (state == TRAP);

endmodule
